gpu_frame_writer: RTL and testbench

// GPU-side drawing engine that fills the back buffer owned by frame_director.

---
 rtl/gpu_frame_writer_if.sv | 29 ++
 rtl/gpu_frame_writer.sv | 181 ++++++++++++++++++
 tb/tb_gpu_frame_writer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_frame_writer_if.sv
// Bundles the frame handshake, the pixel write bus and the rectangle command port.
//   master: frame_director / command source side (drives start, clear colour, commands)
//   slave : gpu_frame_writer side (drives done, pixel writes, cmd_ready)
interface gpu_frame_writer_if;
  logic       gpu_start;
  logic       gpu_done;
  logic [9:0] gpu_x;
  logic [9:0] gpu_y;
  logic [3:0] gpu_data;
  logic       gpu_we;
  logic [3:0] bg_color;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x0;
  logic [9:0] cmd_x1;
  logic [9:0] cmd_y0;
  logic [9:0] cmd_y1;
  logic [3:0] cmd_color;

  modport master (
    output gpu_start, bg_color, cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  gpu_done, gpu_x, gpu_y, gpu_data, gpu_we, cmd_ready
  );

  modport slave (
    input  gpu_start, bg_color, cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output gpu_done, gpu_x, gpu_y, gpu_data, gpu_we, cmd_ready
  );
endinterface

// File: rtl/gpu_frame_writer.sv
// GPU drawing engine filling the back buffer owned by frame_director.
// Per frame (armed by a rising edge of gpu_start) it optionally clears the buffer
// to bg_color, then rasterises the queued solid rectangles, one pixel per clk.
// Ports:
//   clk    : GPU clock (gpu_clk_150)
//   reset  : asynchronous, active-high
//   bus_io : gpu_frame_writer_if.slave -- gpu_start/gpu_done handshake, registered pixel
//            write bus (gpu_x/gpu_y/gpu_data/gpu_we), bg_color, rectangle command port
// Build option: define GPU_FRAME_WRITER_CLEAR_EN to include the full-frame clear phase.
module gpu_frame_writer #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter int unsigned CMD_DEPTH = 8
) (
  input logic              clk,
  input logic              reset,
  gpu_frame_writer_if.slave bus_io
);
  localparam int unsigned      PtrW = $clog2(CMD_DEPTH);
  localparam int unsigned      CntW = PtrW + 1;
  localparam logic [9:0]       XMax = 10'(H_RES - 1);
  localparam logic [9:0]       YMax = 10'(V_RES - 1);
  localparam logic [CntW-1:0]  Full = CntW'(CMD_DEPTH);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StDraw, StFinish} state_e;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    logic [3:0] color;
  } cmd_t;

  state_e          state_q;
  cmd_t            mem_q [CMD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] pend_q;      // commands belonging to the current frame
  logic [2:0]      sync_q;      // [0],[1] synchroniser, [2] previous synced level
  logic [9:0]      cx_q, cy_q, rx0_q, rx1_q, ry1_q;
  logic [3:0]      col_q;
  logic            done_q, we_q;
  logic [9:0]      gx_q, gy_q;
  logic [3:0]      gd_q;
`ifdef GPU_FRAME_WRITER_CLEAR_EN
  logic [3:0]      bg_q;
`endif

  logic       full, push, pop, start_rise;
  cmd_t       head;
  logic [9:0] hx1, hy1;

  assign full       = (count_q == Full);
  assign push       = bus_io.cmd_valid && !full;
  assign pop        = (state_q == StFetch) && (pend_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign hx1        = (head.x1 > XMax) ? XMax : head.x1;
  assign hy1        = (head.y1 > YMax) ? YMax : head.y1;
  assign start_rise = sync_q[1] && !sync_q[2];

  assign bus_io.cmd_ready = !full;
  assign bus_io.gpu_done  = done_q;
  assign bus_io.gpu_we    = we_q;
  assign bus_io.gpu_x     = gx_q;
  assign bus_io.gpu_y     = gy_q;
  assign bus_io.gpu_data  = gd_q;

  // Command storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus_io.cmd_x0, bus_io.cmd_x1, bus_io.cmd_y0, bus_io.cmd_y1,
                          bus_io.cmd_color};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      // Synchroniser resets high so a gpu_start held across reset is not seen as an edge.
      sync_q  <= 3'b111;
      pend_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      ry1_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b1;
      we_q    <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      gd_q    <= '0;
`ifdef GPU_FRAME_WRITER_CLEAR_EN
      bg_q    <= '0;
`endif
    end else begin
      sync_q <= {sync_q[1:0], bus_io.gpu_start};
      we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_rise) begin
            done_q <= 1'b0;
            pend_q <= count_q;
            cx_q   <= '0;
            cy_q   <= '0;
`ifdef GPU_FRAME_WRITER_CLEAR_EN
            bg_q    <= bus_io.bg_color;
            state_q <= StClear;
`else
            state_q <= StFetch;
`endif
          end
        end
`ifdef GPU_FRAME_WRITER_CLEAR_EN
        StClear: begin
          we_q <= 1'b1;
          gx_q <= cx_q;
          gy_q <= cy_q;
          gd_q <= bg_q;
          if (cx_q == XMax) begin
            cx_q <= '0;
            if (cy_q == YMax) state_q <= StFetch;
            else              cy_q    <= cy_q + 10'd1;
          end else begin
            cx_q <= cx_q + 10'd1;
          end
        end
`endif
        StFetch: begin
          if (pend_q == '0) begin
            state_q <= StFinish;
          end else begin
            pend_q <= pend_q - CntW'(1);
            // Empty (or fully off-screen) rectangles are consumed without drawing.
            if (head.x0 <= hx1 && head.y0 <= hy1) begin
              cx_q    <= head.x0;
              cy_q    <= head.y0;
              rx0_q   <= head.x0;
              rx1_q   <= hx1;
              ry1_q   <= hy1;
              col_q   <= head.color;
              state_q <= StDraw;
            end
          end
        end
        StDraw: begin
          we_q <= 1'b1;
          gx_q <= cx_q;
          gy_q <= cy_q;
          gd_q <= col_q;
          if (cx_q == rx1_q) begin
            cx_q <= rx0_q;
            if (cy_q == ry1_q) state_q <= StFetch;
            else               cy_q    <= cy_q + 10'd1;
          end else begin
            cx_q <= cx_q + 10'd1;
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_frame_writer.sv
// Self-checking bench for gpu_frame_writer: expected pixel writes are queued as
// stimulus is issued and compared in order as the DUT emits them.
module tb_gpu_frame_writer;
  localparam int HRes = 320;
  localparam int VRes = 240;
`ifdef GPU_FRAME_WRITER_CLEAR_EN
  localparam bit ClearEn = 1'b1;
  localparam int Bound   = 90000;
`else
  localparam bit ClearEn = 1'b0;
  localparam int Bound   = 2000;
`endif
  localparam int ClearPx = ClearEn ? HRes * VRes : 0;

  logic clk = 1'b0;
  logic reset;
  gpu_frame_writer_if bus ();

  gpu_frame_writer #(.H_RES(HRes), .V_RES(VRes), .CMD_DEPTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int n_writes = 0;
  logic [29:0] sb [$];
  logic [29:0] mon_got, mon_exp;

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.gpu_we === 1'b1) begin
      mon_got = {bus.gpu_x, bus.gpu_y, 6'd0, bus.gpu_data};
      n_writes++;
      last_we_cyc = cyc;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: got x=%0d y=%0d d=%h, required no write",
                 bus.gpu_x, bus.gpu_y, bus.gpu_data);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL write_pixel: got x=%0d y=%0d d=%h, required x=%0d y=%0d d=%h",
                   mon_got[29:20], mon_got[19:10], mon_got[3:0],
                   mon_exp[29:20], mon_exp[19:10], mon_exp[3:0]);
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_px(input int x, input int y, input logic [3:0] c);
    logic [9:0] xv, yv;
    xv = x[9:0];
    yv = y[9:0];
    sb.push_back({xv, yv, 6'd0, c});
  endtask

  task automatic expect_clear(input logic [3:0] c);
    if (ClearEn) begin
      for (int y = 0; y < VRes; y++)
        for (int x = 0; x < HRes; x++) expect_px(x, y, c);
    end
  endtask

  // Reference clipping: bounds beyond the screen are cut, inverted rectangles draw nothing.
  task automatic expect_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [3:0] c);
    int ex1, ey1;
    ex1 = (x1 > HRes - 1) ? HRes - 1 : x1;
    ey1 = (y1 > VRes - 1) ? VRes - 1 : y1;
    for (int y = y0; y <= ey1; y++)
      for (int x = x0; x <= ex1; x++) expect_px(x, y, c);
  endtask

  task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [3:0] c);
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL push_ready: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = x0[9:0];
    bus.cmd_y0    = y0[9:0];
    bus.cmd_x1    = x1[9:0];
    bus.cmd_y1    = y1[9:0];
    bus.cmd_color = c;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Raises gpu_start between edges and checks gpu_done falls exactly on the 3rd edge.
  task automatic start_frame(input bit hold, output int t0);
    @(negedge clk);
    bus.gpu_start = 1'b1;
    t0 = cyc;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.gpu_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_edge2: gpu_done=%b, required 1", bus.gpu_done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.gpu_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_edge3: gpu_done=%b, required 0", bus.gpu_done);
    end
    if (!hold) begin
      @(negedge clk);
      bus.gpu_start = 1'b0;
    end
  endtask

  task automatic wait_done(output int t_done);
    int k;
    k = 0;
    while (bus.gpu_done !== 1'b1 && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    t_done = cyc;
    n_cmp++;
    if (bus.gpu_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: gpu_done=%b after %0d cycles, required 1", bus.gpu_done, k);
    end
  endtask

  task automatic wait_write(input logic [3:0] c, input logic [9:0] y);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.gpu_we === 1'b1 && bus.gpu_data === c && bus.gpu_y === y) && k < Bound);
    n_cmp++;
    if (k >= Bound) begin
      n_err++;
      $display("FAIL draw_timeout: no write of %h on row %0d, required one", c, y);
    end
  endtask

  task automatic check_queue_empty(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d writes outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic check_writes(input string name, input int required);
    n_cmp++;
    if (n_writes != required) begin
      n_err++;
      $display("FAIL %s: %0d writes, required %0d", name, n_writes, required);
    end
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.gpu_start = 1'b0;
    bus.bg_color  = 4'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (bus.gpu_done !== 1'b1) begin n_err++; $display("FAIL rst_done: %b, required 1", bus.gpu_done); end
    if (bus.gpu_we !== 1'b0) begin n_err++; $display("FAIL rst_we: %b, required 0", bus.gpu_we); end
    if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: %b, required 1", bus.cmd_ready); end
    if (bus.gpu_x !== 10'd0) begin n_err++; $display("FAIL rst_x: %0d, required 0", bus.gpu_x); end
    if (bus.gpu_y !== 10'd0) begin n_err++; $display("FAIL rst_y: %0d, required 0", bus.gpu_y); end
    if (bus.gpu_data !== 4'h0) begin n_err++; $display("FAIL rst_data: %h, required 0", bus.gpu_data); end
  endtask

  task automatic test_empty_frame;
    int t0, t1, exp_t;
    bus.bg_color = 4'h3;
    expect_clear(4'h3);
    n_writes = 0;
    start_frame(1'b0, t0);
    wait_done(t1);
    check_queue_empty("empty_missing");
    check_writes("empty_count", ClearPx);
    // Done rises two edges after the last clear write, or 5 edges after start with no clear.
    exp_t = ClearEn ? last_we_cyc + 2 : t0 + 5;
    n_cmp++;
    if (t1 != exp_t) begin
      n_err++;
      $display("FAIL empty_done_time: edge %0d, required edge %0d", t1, exp_t);
    end
  endtask

  task automatic test_rect;
    int t0, t1;
    bus.bg_color = 4'h5;
    expect_clear(4'h5);
    push_cmd(10, 20, 12, 21, 4'hA);
    expect_rect(10, 20, 12, 21, 4'hA);
    n_writes = 0;
    start_frame(1'b0, t0);
    wait_done(t1);
    check_queue_empty("rect_missing");
    check_writes("rect_count", ClearPx + 6);
    n_cmp++;
    if (t1 != last_we_cyc + 2) begin
      n_err++;
      $display("FAIL rect_done_time: edge %0d, required edge %0d", t1, last_we_cyc + 2);
    end
    // Outputs hold the last written pixel while idle.
    n_cmp += 3;
    if (bus.gpu_x !== 10'd12) begin n_err++; $display("FAIL hold_x: %0d, required 12", bus.gpu_x); end
    if (bus.gpu_y !== 10'd21) begin n_err++; $display("FAIL hold_y: %0d, required 21", bus.gpu_y); end
    if (bus.gpu_data !== 4'hA) begin n_err++; $display("FAIL hold_data: %h, required A", bus.gpu_data); end
  endtask

  task automatic test_clip_drop;
    int t0, t1;
    bus.bg_color = 4'h0;
    expect_clear(4'h0);
    push_cmd(300, 230, 400, 300, 4'hC);
    push_cmd(5, 0, 2, 3, 4'h7);
    push_cmd(0, 0, 1, 0, 4'h1);
    expect_rect(300, 230, 400, 300, 4'hC);
    expect_rect(5, 0, 2, 3, 4'h7);
    expect_rect(0, 0, 1, 0, 4'h1);
    n_writes = 0;
    start_frame(1'b0, t0);
    wait_done(t1);
    check_queue_empty("clip_missing");
    check_writes("clip_count", ClearPx + 202);
  endtask

  task automatic test_fifo;
    int t0, t1;
    bus.bg_color = 4'h2;
    expect_clear(4'h2);
    for (int i = 0; i < 8; i++) begin
      push_cmd(i * 4, 50, i * 4 + 3, 50, 4'(i + 1));
      expect_rect(i * 4, 50, i * 4 + 3, 50, 4'(i + 1));
    end
    // Ninth command offered while full must be refused.
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_full: cmd_ready=%b, required 0", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'd200;
    bus.cmd_x1    = 10'd200;
    bus.cmd_y0    = 10'd200;
    bus.cmd_y1    = 10'd200;
    bus.cmd_color = 4'hF;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_full_hold: cmd_ready=%b, required 0", bus.cmd_ready);
    end
    n_writes = 0;
    start_frame(1'b0, t0);
    wait_write(4'h1, 10'd50);
    push_cmd(100, 100, 101, 100, 4'h9);   // belongs to the next frame
    wait_done(t1);
    check_queue_empty("fifo_missing");
    check_writes("fifo_count", ClearPx + 32);
    bus.bg_color = 4'h6;
    expect_clear(4'h6);
    expect_rect(100, 100, 101, 100, 4'h9);
    n_writes = 0;
    start_frame(1'b0, t0);
    wait_done(t1);
    check_queue_empty("deferred_missing");
    check_writes("deferred_count", ClearPx + 2);
  endtask

  task automatic test_reset_mid_draw;
    int t0, t1;
    bus.bg_color = 4'h4;
    expect_clear(4'h4);
    push_cmd(0, 100, 319, 110, 4'h5);
    push_cmd(5, 5, 5, 5, 4'h2);
    expect_rect(0, 100, 319, 110, 4'h5);
    start_frame(1'b1, t0);
    wait_write(4'h5, 10'd100);
    #2;
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (bus.gpu_we !== 1'b0) begin n_err++; $display("FAIL arst_we: %b, required 0", bus.gpu_we); end
    if (bus.gpu_done !== 1'b1) begin n_err++; $display("FAIL arst_done: %b, required 1", bus.gpu_done); end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_writes = 0;
    repeat (20) @(negedge clk);
    n_cmp += 2;
    if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: %b, required 1", bus.cmd_ready); end
    if (bus.gpu_done !== 1'b1) begin n_err++; $display("FAIL held_start: gpu_done=%b, required 1", bus.gpu_done); end
    check_writes("held_start_writes", 0);
    bus.gpu_start = 1'b0;
    repeat (4) @(negedge clk);
    expect_clear(4'h4);
    start_frame(1'b0, t0);
    wait_done(t1);
    check_queue_empty("flush_missing");
    check_writes("flush_count", ClearPx);
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_rect();
    test_clip_drop();
    test_fifo();
    test_reset_mid_draw();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
